// File: rtl/dsm_pkg.sv
// Shared constants and FSM encoding for the delta-sigma interpolator and DAC.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dsm_pkg;

  // Default sample width and oversampling ratio (log2), shared with dsm_dac.
  localparam int DSM_DATA_WIDTH = 16;
  localparam int DSM_OSR_LOG2   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dsm_state_t;

endpackage

// File: rtl/dsm_strobe_gen.sv
// Programmable strobe divider: o_strobe asserts once every i_div+1 clocks.
// Latency: o_strobe is combinational from the count register; the consumer registers it.
// Backpressure: none, free running.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst    - synchronous active-high reset, count returns to 0
//   i_div    - strobe period minus one
//   o_strobe - high in the cycle the count has reached i_div
module dsm_strobe_gen
  import dsm_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_strobe
);

  logic [DIV_WIDTH-1:0] cnt;

  // Comparing with >= rather than == means a shrinking i_div cuts the current
  // period short instead of letting the count run all the way round.
  assign o_strobe = (cnt >= i_div);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (o_strobe) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/dsm_interp.sv
// Linear interpolator feeding a DSM DAC: 2^OSR_LOG2 output strobes per input sample.
// Latency: o_data updates on the edge that raises o_en; a sample takes effect at the next segment wrap.
// Backpressure: single-entry holding register, o_ready low while it is full.
//
// Ports:
//   i_clk, i_rst     - clock and synchronous active-high reset
//   i_div            - strobe period minus one
//   i_valid, i_data  - low-rate sample in, transferred when i_valid && o_ready
//   o_ready          - holding register empty
//   o_data, o_en     - interpolated sample and one-cycle strobe, to dsm_dac i_data / i_en
//   o_underrun       - sticky, set when a segment ends with no new sample
//   i_clr_underrun   - clears o_underrun (a simultaneous set wins)
module dsm_interp
  import dsm_pkg::*;
#(
  parameter int DATA_WIDTH = DSM_DATA_WIDTH,
  parameter int OSR_LOG2   = DSM_OSR_LOG2,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [DIV_WIDTH-1:0]         i_div,
  input  logic                         i_valid,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic                         o_ready,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_en,
  output logic                         o_underrun,
  input  logic                         i_clr_underrun
);

  localparam int ACC_WIDTH = DATA_WIDTH + OSR_LOG2;

  dsm_state_t                   state;
  dsm_state_t                   state_next;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [DATA_WIDTH:0]   step;
  logic        [OSR_LOG2-1:0]   phase;
  logic signed [DATA_WIDTH-1:0] endpoint;
  logic signed [DATA_WIDTH-1:0] held;
  logic                         full;
  logic                         full_next;
  logic                         strobe;
  logic                         accept;
  logic                         consume;
  logic                         set_underrun;
  logic                         wrap;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic signed [DATA_WIDTH:0]   step_to_held;

  dsm_strobe_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_strobe_gen (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_div   (i_div),
    .o_strobe(strobe)
  );

  assign accept = i_valid && o_ready;
  assign wrap   = (phase == '1);

  // acc always lies between two endpoints scaled by 2^OSR_LOG2, and step is one
  // bit wider than a sample, so neither sum nor difference can overflow.
  assign acc_sum      = acc + ACC_WIDTH'(step);
  assign step_to_held = (DATA_WIDTH + 1)'(held) - (DATA_WIDTH + 1)'(endpoint);

  always_comb begin
    state_next   = state;
    consume      = 1'b0;
    set_underrun = 1'b0;
    unique case (state)
      IDLE: begin
        if (strobe && full) begin
          state_next = RUN;
          consume    = 1'b1;
        end
      end
      RUN: begin
        if (strobe && wrap) begin
          consume      = full;
          set_underrun = !full;
        end
      end
      default: state_next = IDLE;
    endcase

    // accept requires o_ready, i.e. an empty register, so it never meets consume.
    full_next = full;
    if (accept) begin
      full_next = 1'b1;
    end else if (consume) begin
      full_next = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      acc        <= '0;
      step       <= '0;
      phase      <= '0;
      endpoint   <= '0;
      held       <= '0;
      full       <= 1'b0;
      o_ready    <= 1'b0;
      o_data     <= '0;
      o_en       <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      state   <= state_next;
      full    <= full_next;
      o_ready <= !full_next;
      o_en    <= strobe;

      if (accept) begin
        held <= i_data;
      end

      if (set_underrun) begin
        o_underrun <= 1'b1;
      end else if (i_clr_underrun) begin
        o_underrun <= 1'b0;
      end

      if (strobe) begin
        if (state == IDLE) begin
          // First segment starts from 0; endpoint is still 0 here, so
          // step_to_held is simply the held sample.
          if (full) begin
            acc      <= '0;
            phase    <= '0;
            endpoint <= held;
            step     <= step_to_held;
          end
        end else begin
          acc    <= acc_sum;
          phase  <= phase + OSR_LOG2'(1);
          // Upper bits of the two's complement accumulator are a floor shift.
          o_data <= acc_sum[ACC_WIDTH-1:OSR_LOG2];
          if (wrap) begin
            if (full) begin
              endpoint <= held;
              step     <= step_to_held;
            end else begin
              // Hold the current endpoint for a whole segment and retry next wrap.
              step <= '0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dsm_interp.sv
module tb_dsm_interp;

  localparam int DW   = 16;
  localparam int OSR  = 2;
  localparam int DIVW = 8;
  localparam int NSEG = 1 << OSR;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DIVW-1:0]      div;
  logic                 valid;
  logic signed [DW-1:0] data;
  logic                 clr;
  logic                 ready;
  logic signed [DW-1:0] odata;
  logic                 en;
  logic                 ur;

  always #5 clk = ~clk;

  dsm_interp #(
    .DATA_WIDTH(DW),
    .OSR_LOG2  (OSR),
    .DIV_WIDTH (DIVW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_div         (div),
    .i_valid       (valid),
    .i_data        (data),
    .o_ready       (ready),
    .o_data        (odata),
    .o_en          (en),
    .o_underrun    (ur),
    .i_clr_underrun(clr)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: segments as endpoint pairs, output = A + floor(k*(B-A)/N).
  int n;
  bit running;
  int seg_a, seg_b, seg_k;
  int exp_data;
  bit exp_ur;
  int pending[$];
  bit accepted;
  bit en_free;
  bit prev_en;

  typedef struct {
    int sample;
    int exp[4];
  } seg_t;
  seg_t tbl[4];

  function automatic int floor_div(int x, int d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  task automatic check(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, expv);
    end
  endtask

  task automatic model_strobe(output bit set_ur);
    set_ur = 1'b0;
    if (!running) begin
      if (pending.size() > 0) begin
        running = 1'b1;
        seg_a   = 0;
        seg_b   = pending.pop_front();
        seg_k   = 0;
      end
    end else begin
      seg_k++;
      exp_data = seg_a + floor_div(seg_k * (seg_b - seg_a), NSEG);
      if (seg_k == NSEG) begin
        seg_k = 0;
        seg_a = seg_b;
        if (pending.size() > 0) seg_b = pending.pop_front();
        else set_ur = 1'b1;
      end
    end
  endtask

  // One clock: inputs were set before the call; outputs compared 1ns after the edge.
  task automatic cycle();
    bit acc_now, clr_now, rst_now, set_now, strobe_now;
    int exp_ready;
    acc_now = valid && ready;
    clr_now = clr;
    rst_now = rst;
    @(posedge clk);
    #1;
    set_now    = 1'b0;
    strobe_now = 1'b0;
    if (rst_now) begin
      n        = 0;
      running  = 1'b0;
      pending.delete();
      exp_data = 0;
      exp_ur   = 1'b0;
      seg_k    = 0;
    end else begin
      n++;
      strobe_now = ((n % (int'(div) + 1)) == 0);
      if (strobe_now && !en_free) model_strobe(set_now);
      if (acc_now) pending.push_back(int'(data));
      if (set_now) exp_ur = 1'b1;
      else if (clr_now) exp_ur = 1'b0;
    end
    accepted  = acc_now && !rst_now;
    exp_ready = (!rst_now && pending.size() == 0) ? 1 : 0;
    if (!en_free) check("o_en", int'(en), int'(strobe_now));
    else if (div != 0) check("o_en_width", int'(prev_en && en), 0);
    check("o_data", int'(odata), exp_data);
    check("o_ready", int'(ready), exp_ready);
    check("o_underrun", int'(ur), int'(exp_ur));
    prev_en = en;
  endtask

  task automatic wait_strobe();
    for (int i = 0; i < 64; i++) begin
      cycle();
      if (en) return;
    end
    check("strobe_timeout", 0, 1);
  endtask

  task automatic send(int s);
    bit done;
    done  = 1'b0;
    valid = 1'b1;
    data  = DW'(s);
    for (int i = 0; i < 64 && !done; i++) begin
      cycle();
      done = accepted;
    end
    valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic wait_pre_strobe();
    for (int i = 0; i < 64; i++) begin
      if (((n + 1) % (int'(div) + 1)) == 0) return;
      cycle();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int en_cnt;

    tbl[0].sample = 400;    tbl[0].exp = '{100, 200, 300, 400};
    tbl[1].sample = -400;   tbl[1].exp = '{200, 0, -200, -400};
    tbl[2].sample = 32767;  tbl[2].exp = '{7891, 16183, 24475, 32767};
    tbl[3].sample = -32768; tbl[3].exp = '{16383, -1, -16385, -32768};

    rst = 1'b1; div = 8'd3; valid = 1'b0; data = '0; clr = 1'b0;
    en_free = 1'b0; prev_en = 1'b0; n = 0; running = 1'b0;
    exp_data = 0; exp_ur = 1'b0; seg_k = 0; seg_a = 0; seg_b = 0;

    // Reset held for three cycles, then idle strobing.
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    check("ready_after_release", int'(ready), 1);
    repeat (7) cycle();

    // Segment table: ramp, negative step, extremes.
    send(tbl[0].sample);
    wait_strobe();
    check("startup_data", int'(odata), 0);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) send(tbl[i + 1].sample);
      for (int j = 0; j < NSEG; j++) begin
        wait_strobe();
        check($sformatf("seg%0d_k%0d", i, j + 1), int'(odata), tbl[i].exp[j]);
      end
    end

    // Underrun: hold last endpoint, set beats clear, clear alone works.
    check("ur_set_at_wrap", int'(ur), 1);
    for (int j = 0; j < 3; j++) begin
      wait_strobe();
      check("ur_hold_data", int'(odata), -32768);
    end
    wait_pre_strobe();
    clr = 1'b1;
    cycle();
    check("ur_set_wins", int'(ur), 1);
    cycle();
    clr = 1'b0;
    check("ur_clear_alone", int'(ur), 0);

    // Backpressure: valid held high with back-to-back random samples.
    cnt   = 0;
    valid = 1'b1;
    data  = DW'($urandom_range(0, 65535));
    for (int i = 0; i < 1000 && cnt < 10; i++) begin
      cycle();
      if (accepted) begin
        cnt++;
        data = DW'($urandom_range(0, 65535));
      end
    end
    valid = 1'b0;
    check("bp_accepted", cnt, 10);

    // Reset in the middle of a segment, then restart from zero.
    wait_strobe();
    wait_strobe();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    check("midrst_ready", int'(ready), 1);
    check("midrst_data", int'(odata), 0);
    send(1000);
    wait_strobe();
    check("restart_idle_data", int'(odata), 0);
    wait_strobe();
    check("restart_first", int'(odata), 250);

    // Divider of zero strobes every cycle.
    div = 8'd0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (en) en_cnt++;
    end
    check("div0_every_cycle", en_cnt, 6);

    // Divider changes on the fly: pulses never merge.
    div = 8'd4;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    en_free = 1'b1;
    en_cnt  = 0;
    for (int i = 0; i < 80; i++) begin
      if (i % 5 == 0) div = DIVW'($urandom_range(1, 6));
      cycle();
      if (en) en_cnt++;
    end
    check("div_change_some_pulses", int'(en_cnt > 5), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
